// File: rtl/freq_readout.sv
// Display stage for the frequency multiplier: captures k on a valid rise, converts it to BCD
// with a double-dabble engine and scans it onto an active-low 3-digit seven-segment display.
module freq_readout #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] k_i,
  output logic [3:0] bcd_hun_o,
  output logic [3:0] bcd_ten_o,
  output logic [3:0] bcd_one_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [6:0] seg_o,
  output logic [2:0] an_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e          state_q, state_d;
  logic            valid_q;
  logic [7:0]      shift_q, shift_d;
  logic [11:0]     scratch_q, scratch_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [CntW-1:0] scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic [11:0]     adj;
  logic            rise;
  logic            unused_adj_msb;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign rise = valid_i & ~valid_q;
  assign adj  = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  // Hundreds never exceeds 2, so the corrected MSB is always shifted out as zero.
  assign unused_adj_msb = adj[11];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          shift_d   = k_i;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        scratch_d = {adj[10:0], shift_q[7]};
        shift_d   = {shift_q[6:0], 1'b0};
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scan_d = scan_q + CntW'(1);
    idx_d  = idx_q;
    if (scan_q == CntW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      scan_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_i;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    logic [3:0] dig;
    logic       blank;
    dig   = bcd_q[3:0];
    blank = 1'b0;
    an_o  = 3'b110;
    unique case (idx_q)
      2'd0: begin
        an_o = 3'b110;
        dig  = bcd_q[3:0];
      end
      2'd1: begin
        an_o  = 3'b101;
        dig   = bcd_q[7:4];
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        an_o  = 3'b011;
        dig   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        an_o  = 3'b111;
        blank = 1'b1;
      end
    endcase
    seg_o = blank ? 7'b1111111 : decode(dig);
  end

  assign bcd_hun_o = bcd_q[11:8];
  assign bcd_ten_o = bcd_q[7:4];
  assign bcd_one_o = bcd_q[3:0];
  assign busy_o    = (state_q == StConv);
  assign done_o    = done_q;

endmodule

// File: tb/tb_freq_readout.sv
// Directed bench for freq_readout with a short scan period so every digit slot is reachable.
module tb_freq_readout;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [7:0] k;
  logic [3:0] bcd_hun, bcd_ten, bcd_one;
  logic       busy, done;
  logic [6:0] seg;
  logic [2:0] an;
  logic [11:0] bcd;

  int n_cmp = 0;
  int n_mis = 0;

  freq_readout #(.SCAN_DIV(4)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid),
    .k_i      (k),
    .bcd_hun_o(bcd_hun),
    .bcd_ten_o(bcd_ten),
    .bcd_one_o(bcd_one),
    .busy_o   (busy),
    .done_o   (done),
    .seg_o    (seg),
    .an_o     (an)
  );

  assign bcd = {bcd_hun, bcd_ten, bcd_one};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] kv);
    valid = 1'b0;
    k     = kv;
    tick();
    valid = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      tick();
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_slot(input string tag, input logic [2:0] an_exp, input logic [6:0] seg_exp);
    int found;
    found = 0;
    for (int i = 0; i < 16; i++) begin
      if (an == an_exp) begin
        found = 1;
        break;
      end
      tick();
    end
    if (found != 0) check(tag, seg, seg_exp);
    else check({tag, "_an_timeout"}, an, an_exp);
  endtask

  initial begin
    logic [2:0] an_tab [3];
    int busy_cnt;
    int done_cnt;
    an_tab = '{3'b110, 3'b101, 3'b011};
    rst   = 1'b1;
    valid = 1'b0;
    k     = 8'd0;
    tick();
    tick();

    check("rst_bcd", bcd, 12'h000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_an", an, 3'b110);
    check("rst_seg", seg, 7'b1000000);

    // Scan from reset: each digit held exactly 4 cycles.
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      check($sformatf("scan_an_%0d", i), an, an_tab[(i / 4) % 3]);
      tick();
    end

    // k = 255
    start(8'd255);
    tick();
    check("k255_busy_e0", busy, 1);
    busy_cnt = 1;
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 4) check("k255_hold", bcd, 12'h000);
    end
    check("k255_busy_cycles", busy_cnt, 8);
    check("k255_done_e8", done, 1);
    check("k255_done_cnt", done_cnt, 1);
    check("k255_bcd", bcd, 12'h255);
    tick();
    check("k255_done_pulse", done, 0);
    check_slot("k255_seg_one", 3'b110, 7'b0010010);
    check_slot("k255_seg_ten", 3'b101, 7'b0010010);
    check_slot("k255_seg_hun", 3'b011, 7'b0100100);

    // Blanking
    start(8'd7);
    wait_done("k7");
    check("k7_bcd", bcd, 12'h007);
    check_slot("k7_seg_ten", 3'b101, 7'b1111111);
    check_slot("k7_seg_hun", 3'b011, 7'b1111111);
    check_slot("k7_seg_one", 3'b110, 7'b1111000);

    start(8'd0);
    wait_done("k0");
    check("k0_bcd", bcd, 12'h000);
    check_slot("k0_seg_one", 3'b110, 7'b1000000);
    check_slot("k0_seg_ten", 3'b101, 7'b1111111);
    check_slot("k0_seg_hun", 3'b011, 7'b1111111);

    // valid held high for 50 cycles with k changing mid-way
    start(8'd123);
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) k = 8'd45;
      tick();
      if (done) done_cnt++;
    end
    check("held_done_cnt", done_cnt, 1);
    check("held_bcd", bcd, 12'h123);

    // Rise during conversion is ignored
    start(8'd42);
    tick();
    valid = 1'b0;
    tick();
    tick();
    k     = 8'd99;
    valid = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midrise_done_cnt", done_cnt, 1);
    check("midrise_bcd", bcd, 12'h042);
    start(8'd99);
    wait_done("k99");
    check("k99_bcd", bcd, 12'h099);

    // Reset mid-conversion
    start(8'd200);
    tick();
    tick();
    tick();
    tick();
    check("midrst_busy_before", busy, 1);
    rst   = 1'b1;
    valid = 1'b0;
    tick();
    check("midrst_bcd", bcd, 12'h000);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_an", an, 3'b110);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_bcd_after", bcd, 12'h000);

    // valid high across reset counts as a fresh rise
    rst   = 1'b1;
    k     = 8'd5;
    valid = 1'b1;
    tick();
    rst = 1'b0;
    wait_done("rst_rise");
    check("rst_rise_bcd", bcd, 12'h005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/freq_readout.md
# freq_readout

Downstream display stage for the frequency multiplier. It captures the 8-bit multiplication factor `k` each time the multiplier asserts `valid` and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low 3-digit seven-segment display with leading-zero blanking. Sits between the multiplier's `k`/`valid` outputs and the board display pins.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each digit stays enabled during display scan. Legal values are ≥ 2.
- `clk`  in  1  system reference clock (same clock as the multiplier's `clk`). Single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `valid`  in  1  level from the multiplier. A rising edge means `k` is settled.
- `k`  in  8  multiplication factor, unsigned 0..255.
- `bcd_hun`  out  4  hundreds digit of the last converted `k`.
- `bcd_ten`  out  4  tens digit.
- `bcd_one`  out  4  ones digit.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when the `bcd_*` outputs update.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `an`  out  3  digit enables, active-low one-hot. Bit 0 = ones, bit 1 = tens, bit 2 = hundreds.

## Operation
- **Edge detect:** `valid` is registered into `valid_q`. `rise = valid & ~valid_q`.
- **States:**
  - IDLE
    - On `rise`: load `k` into an 8-bit shift register, clear the 12-bit BCD scratch register, set iteration count = 0, go to CONV.
    - Otherwise stay in IDLE.
  - CONV, one iteration per cycle:
    - In the scratch register, add 3 to every nibble ≥ 5.
    - Shift `{scratch, shift}` left by 1.
    - Increment the count.
    - On the 8th iteration (count == 7): write the scratch result to `bcd_hun/ten/one`, pulse `done`, go to IDLE.
- **Rise during CONV:** ignored. No restart, no queueing; `k` is not re-sampled. `valid` held high triggers exactly one conversion.
- **Arithmetic:** the maximum input 255 gives digits 2/5/5. The hundreds nibble never exceeds 2. The add-3 correction uses the pre-shift nibble value.
- **Outputs during CONV:** `bcd_*` hold the previous result until the final iteration.
- **Scan counter:**
  - Counts 0..`SCAN_DIV`-1 continuously, independent of conversion state.
  - At terminal count, the digit index advances 0→1→2→0.
- **Digit select:**
  - `an` = 3'b110 / 3'b101 / 3'b011 for index 0 / 1 / 2.
  - `seg` = the selected digit decoded combinationally from registered state.
- **Blanking** (`seg` = 7'b1111111 for a blanked digit):
  - Hundreds is blanked when `bcd_hun` == 0.
  - Tens is blanked when `bcd_hun` == 0 and `bcd_ten` == 0.
  - Ones is never blanked.
- **Decode (gfedcba):** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any value >9 = 1111111.

## Timing
- **Reset values:**

  | Signal | Value |
  |---|---|
  | `bcd_*` | 0 |
  | `busy` | 0 |
  | `done` | 0 |
  | state | IDLE |
  | `valid_q` | 0 |
  | scan count, index | 0 |
  | `an` | 3'b110 |
  | `seg` | 7'b1000000 (ones shows '0') |

- **Capture:** `rise` sampled at edge E0 loads `k`. `busy` is 1 from after E0.
- **Conversion:** iterations occur at edges E1..E8. At E8, `bcd_*` update, `done` = 1 for the cycle after E8, and `busy` returns to 0.
- **Latency:** 8 cycles from the capture edge to new outputs.
- **Earliest re-capture:** a new `rise` can be captured at edge E9.
- **Reset mid-CONV:** aborts the conversion, with all outputs at reset values on the next cycle. A `valid` still high after reset counts as a rise, since `valid_q` = 0.
- **Digit dwell:** each digit is enabled for exactly `SCAN_DIV` cycles. The index changes on the edge where scan count wraps from `SCAN_DIV`-1 to 0.

## Test plan
- **k = 255:**
  - Stimulus: reset, then raise `valid` with `k` = 255.
  - After 8 cycles: `bcd` = 2/5/5, one-cycle `done`, `busy` high exactly 8 cycles.
  - Scanned `seg`: ones = 0010010, tens = 0010010, hundreds = 0100100.
- **Blanking:**
  - `k` = 7 gives `bcd` 0/0/7. `seg` is 1111111 on the tens and hundreds slots and 1111000 on the ones slot.
  - `k` = 0 shows a single '0'.
- **`valid` held high:** hold high 50 cycles, changing `k` mid-way. Exactly one `done` occurs and `bcd` reflects `k` at the rise.
- **Rise during CONV:** drop `valid`, then raise it again 3 cycles after the capture edge with `k` = 99. It is ignored and `bcd` keeps the first value. A later rise after `busy` falls converts 99 → 0/9/9.
- **Reset mid-CONV:** assert `rst` at E4 with `k` = 200. Next cycle: `bcd` = 0, `busy` = 0, `done` never pulses, `an` = 110.
- **Scan timing:** with `SCAN_DIV` = 4, `an` cycles 110→101→011→110, each held for exactly 4 cycles, from reset.
